// File: rtl/tick_bcd_counter.sv
// tick_bcd_counter: prescaled tick generator driving an NUM_DIGITS-digit BCD
// counter with programmable terminal count, direction, pause, clear and load.
// wrap_o marks the wrap/borrow so stages can be chained (s -> min -> h).
// Optional build macro: TICK_COUNTER_SATURATE_EN (one-shot timer: hold at the
// terminal value instead of wrapping; clear or load re-arms).
module tick_bcd_counter #(
  parameter int TICK_PERIOD = 50000000,
  parameter int NUM_DIGITS  = 2,
  parameter int MAX_VALUE   = 59
) (
  input  logic                    CLOCK_50_I,
  input  logic                    reset,
  input  logic                    enable_i,
  input  logic                    up_down_i,
  input  logic                    clear_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] load_value_i,
  output logic                    tick_o,
  output logic [4*NUM_DIGITS-1:0] count_o,
  output logic                    wrap_o,
  output logic                    err_o
);

  localparam int PRESC_W = $clog2(TICK_PERIOD);
  localparam int COUNT_W = 4 * NUM_DIGITS;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_PERIOD - 1);

  // Decimal terminal count converted to packed BCD at elaboration time.
  function automatic logic [COUNT_W-1:0] to_bcd(input int value);
    logic [COUNT_W-1:0] result;
    int                 rest;
    result = '0;
    rest   = value;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      result[4*i +: 4] = 4'(rest % 10);
      rest             = rest / 10;
    end
    return result;
  endfunction

  localparam logic [COUNT_W-1:0] MAX_BCD = to_bcd(MAX_VALUE);

  logic [PRESC_W-1:0]    prescaler_reg, prescaler_next;
  logic [COUNT_W-1:0]    count_reg, count_next;
  logic                  wrap_reg, wrap_next;
  logic                  err_reg, err_next;

  logic [COUNT_W-1:0]    inc_value;
  logic [COUNT_W-1:0]    dec_value;
  logic [NUM_DIGITS-1:0] carry;
  logic [NUM_DIGITS-1:0] borrow;
  logic [NUM_DIGITS-1:0] digit_ok;
  logic                  load_ok;
  logic                  tick_int;

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  // Per-digit BCD increment/decrement with ripple carry/borrow, plus load digit check.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] digit;
      assign digit = count_reg[4*gi +: 4];

      assign inc_value[4*gi +: 4] = !carry[gi]  ? digit :
                                    (digit == 4'd9) ? 4'd0 : digit + 4'd1;
      assign dec_value[4*gi +: 4] = !borrow[gi] ? digit :
                                    (digit == 4'd0) ? 4'd9 : digit - 4'd1;
      assign digit_ok[gi] = (load_value_i[4*gi +: 4] <= 4'd9);

      if (gi < NUM_DIGITS - 1) begin : g_chain
        assign carry[gi+1]  = carry[gi]  && (digit == 4'd9);
        assign borrow[gi+1] = borrow[gi] && (digit == 4'd0);
      end
    end
  endgenerate

  // With every digit valid, BCD ordering matches binary ordering of the vector.
  assign load_ok = (&digit_ok) && (load_value_i <= MAX_BCD);

  // Tick is suppressed by clear/load, and forced low while reset is held.
  assign tick_int = enable_i && (prescaler_reg == PRESC_LAST) && !clear_i && !load_i;
  assign tick_o   = tick_int && !reset;

  assign count_o = count_reg;
  assign wrap_o  = wrap_reg;
  assign err_o   = err_reg;

  // Next-state: clear beats load beats tick; pulses default low every cycle.
  always_comb begin
    prescaler_next = prescaler_reg;
    count_next     = count_reg;
    wrap_next      = 1'b0;
    err_next       = 1'b0;
    if (clear_i) begin
      count_next     = '0;
      prescaler_next = '0;
    end else if (load_i) begin
      if (load_ok) begin
        count_next     = load_value_i;
        prescaler_next = '0;
      end else begin
        err_next = 1'b1;
      end
    end else if (enable_i) begin
      prescaler_next = (prescaler_reg == PRESC_LAST) ? '0 : prescaler_reg + PRESC_W'(1);
      if (tick_int) begin
`ifdef TICK_COUNTER_SATURATE_EN
        if (up_down_i) begin
          if (count_reg != MAX_BCD) begin
            count_next = inc_value;
            wrap_next  = (inc_value == MAX_BCD);
          end
        end else begin
          if (count_reg != '0) begin
            count_next = dec_value;
            wrap_next  = (dec_value == '0);
          end
        end
`else
        if (up_down_i) begin
          if (count_reg == MAX_BCD) begin
            count_next = '0;
            wrap_next  = 1'b1;
          end else begin
            count_next = inc_value;
          end
        end else begin
          if (count_reg == '0) begin
            count_next = MAX_BCD;
            wrap_next  = 1'b1;
          end else begin
            count_next = dec_value;
          end
        end
`endif
      end
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge CLOCK_50_I or posedge reset) begin
    if (reset) begin
      prescaler_reg <= '0;
      count_reg     <= '0;
      wrap_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      prescaler_reg <= prescaler_next;
      count_reg     <= count_next;
      wrap_reg      <= wrap_next;
      err_reg       <= err_next;
    end
  end

endmodule
